// File: rtl/axis_dot_param.sv
// Run-time loadable fixed-point matrix-vector engine: N_OUT x N_IN weights arrive
// on a weight stream, each N_IN-word input vector yields N_OUT saturated dot products.
module axis_dot_param #(
  parameter int N_IN   = 20,
  parameter int N_OUT  = 10,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int ACC_W  = 72
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] WEIGHT_AXIS_TDATA,
  input  logic              WEIGHT_AXIS_TLAST,
  input  logic              WEIGHT_AXIS_TVALID,
  output logic              WEIGHT_AXIS_TREADY,
  input  logic [DATA_W-1:0] INPUT_AXIS_TDATA,
  input  logic              INPUT_AXIS_TLAST,
  input  logic              INPUT_AXIS_TVALID,
  output logic              INPUT_AXIS_TREADY,
  output logic [DATA_W-1:0] OUTPUT_AXIS_TDATA,
  output logic              OUTPUT_AXIS_TLAST,
  output logic              OUTPUT_AXIS_TVALID,
  input  logic              OUTPUT_AXIS_TREADY,
  output logic              err_len,
  output logic              busy
);

  localparam int N_W = N_IN * N_OUT;
  localparam int K_W = $clog2(N_W);
  localparam int I_W = $clog2(N_IN);
  localparam int J_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [K_W-1:0] K_LAST = K_W'(N_W - 1);
  localparam logic [I_W-1:0] I_LAST = I_W'(N_IN - 1);
  localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  if (N_IN < 2 || ACC_W < 2*DATA_W + $clog2(N_IN)) begin : g_param_check
    $fatal(1, "axis_dot_param: N_IN must be >= 2 and ACC_W >= 2*DATA_W+clog2(N_IN)");
  end

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, MAC, OUT} state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] w_mem [N_W];
  logic signed [DATA_W-1:0] x_mem [N_IN];

  logic [K_W-1:0] k;   // weight write address, then row-major read address in MAC
  logic [I_W-1:0] i;
  logic [J_W-1:0] j;
  logic signed [ACC_W-1:0] acc;
  logic [DATA_W-1:0] result;
  logic weights_valid;

  logic w_hs, x_hs, o_hs, k_last, i_last, j_last;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_sum, acc_shr;
  logic [DATA_W-1:0] sat_val;

  assign w_hs   = (state == LOAD_W) && WEIGHT_AXIS_TVALID;
  assign x_hs   = (state == LOAD_X) && INPUT_AXIS_TVALID;
  assign o_hs   = (state == OUT) && OUTPUT_AXIS_TREADY;
  assign k_last = (k == K_LAST);
  assign i_last = (i == I_LAST);
  assign j_last = (j == J_LAST);

  assign prod    = w_mem[k] * x_mem[i];
  assign acc_sum = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign acc_shr = acc_sum >>> FRAC_W;

  always_comb begin
    sat_val = acc_shr[DATA_W-1:0];
    if (acc_shr > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (acc_shr < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
  end

  // NOTE: every signal driven here gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (WEIGHT_AXIS_TVALID)                      state_nxt = LOAD_W;
        else if (INPUT_AXIS_TVALID && weights_valid) state_nxt = LOAD_X;
      end
      LOAD_W: if (w_hs && (k_last || WEIGHT_AXIS_TLAST)) state_nxt = IDLE;
      LOAD_X: begin
        if (x_hs && i_last)                 state_nxt = MAC;
        else if (x_hs && INPUT_AXIS_TLAST)  state_nxt = IDLE;
      end
      MAC:    if (i_last) state_nxt = OUT;
      OUT:    if (o_hs)   state_nxt = j_last ? IDLE : MAC;
      default:            state_nxt = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state         <= IDLE;
      k             <= '0;
      i             <= '0;
      j             <= '0;
      acc           <= '0;
      result        <= '0;
      weights_valid <= 1'b0;
      err_len       <= 1'b0;
    end else begin
      state   <= state_nxt;
      err_len <= 1'b0;
      case (state)
        IDLE: begin
          k <= '0;
          i <= '0;
          if (WEIGHT_AXIS_TVALID) weights_valid <= 1'b0;
        end
        LOAD_W: if (w_hs) begin
          k <= k + K_W'(1);
          if (k_last) begin
            weights_valid <= 1'b1;
            err_len       <= !WEIGHT_AXIS_TLAST;
          end else if (WEIGHT_AXIS_TLAST) begin
            err_len <= 1'b1;
          end
        end
        LOAD_X: if (x_hs) begin
          i <= i_last ? '0 : i + I_W'(1);
          if (i_last) begin
            k       <= '0;
            j       <= '0;
            acc     <= '0;
            err_len <= !INPUT_AXIS_TLAST;
          end else if (INPUT_AXIS_TLAST) begin
            err_len <= 1'b1;
          end
        end
        MAC: begin
          k   <= k + K_W'(1);
          i   <= i_last ? '0 : i + I_W'(1);
          acc <= acc_sum;
          if (i_last) result <= sat_val;
        end
        OUT: if (o_hs) begin
          j   <= j + J_W'(1);
          acc <= '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: storage arrays are not reset; weights_valid guards stale contents and
  // keeps them mappable to plain registers or distributed RAM.
  always_ff @(posedge aclk) begin
    if (!rst && w_hs) w_mem[k] <= WEIGHT_AXIS_TDATA;
    if (!rst && x_hs) x_mem[i] <= INPUT_AXIS_TDATA;
  end

  assign WEIGHT_AXIS_TREADY = (state == LOAD_W);
  assign INPUT_AXIS_TREADY  = (state == LOAD_X);
  assign OUTPUT_AXIS_TVALID = (state == OUT);
  assign OUTPUT_AXIS_TLAST  = (state == OUT) && j_last;
  assign OUTPUT_AXIS_TDATA  = result;
  assign busy               = (state != IDLE);

endmodule

// File: tb/tb_axis_dot_param.sv
// Directed bench for axis_dot_param: a 4x3 instance for function, framing and
// saturation, plus a default 20x10 instance against a small integer model.
module tb_axis_dot_param;

  logic aclk = 1'b0;
  logic rst;
  always #5 aclk = ~aclk;

  logic        big;
  logic [31:0] w_tdata, x_tdata;
  logic        w_tlast, w_tvalid, x_tlast, x_tvalid, o_tready;

  logic [31:0] s_o_tdata, b_o_tdata;
  logic s_w_tready, s_x_tready, s_o_tlast, s_o_tvalid, s_err, s_busy;
  logic b_w_tready, b_x_tready, b_o_tlast, b_o_tvalid, b_err, b_busy;

  axis_dot_param #(.N_IN(4), .N_OUT(3), .DATA_W(32), .FRAC_W(16), .ACC_W(72)) dut (
    .aclk(aclk), .rst(rst),
    .WEIGHT_AXIS_TDATA(w_tdata), .WEIGHT_AXIS_TLAST(w_tlast),
    .WEIGHT_AXIS_TVALID(w_tvalid & ~big), .WEIGHT_AXIS_TREADY(s_w_tready),
    .INPUT_AXIS_TDATA(x_tdata), .INPUT_AXIS_TLAST(x_tlast),
    .INPUT_AXIS_TVALID(x_tvalid & ~big), .INPUT_AXIS_TREADY(s_x_tready),
    .OUTPUT_AXIS_TDATA(s_o_tdata), .OUTPUT_AXIS_TLAST(s_o_tlast),
    .OUTPUT_AXIS_TVALID(s_o_tvalid), .OUTPUT_AXIS_TREADY(o_tready),
    .err_len(s_err), .busy(s_busy)
  );

  axis_dot_param dut_big (
    .aclk(aclk), .rst(rst),
    .WEIGHT_AXIS_TDATA(w_tdata), .WEIGHT_AXIS_TLAST(w_tlast),
    .WEIGHT_AXIS_TVALID(w_tvalid & big), .WEIGHT_AXIS_TREADY(b_w_tready),
    .INPUT_AXIS_TDATA(x_tdata), .INPUT_AXIS_TLAST(x_tlast),
    .INPUT_AXIS_TVALID(x_tvalid & big), .INPUT_AXIS_TREADY(b_x_tready),
    .OUTPUT_AXIS_TDATA(b_o_tdata), .OUTPUT_AXIS_TLAST(b_o_tlast),
    .OUTPUT_AXIS_TVALID(b_o_tvalid), .OUTPUT_AXIS_TREADY(o_tready),
    .err_len(b_err), .busy(b_busy)
  );

  // Views of whichever instance is currently selected by 'big'
  logic        w_tready, x_tready, o_tvalid, o_tlast, busy;
  logic [31:0] o_tdata;
  assign w_tready = big ? b_w_tready : s_w_tready;
  assign x_tready = big ? b_x_tready : s_x_tready;
  assign o_tvalid = big ? b_o_tvalid : s_o_tvalid;
  assign o_tlast  = big ? b_o_tlast  : s_o_tlast;
  assign o_tdata  = big ? b_o_tdata  : s_o_tdata;
  assign busy     = big ? b_busy     : s_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  int cyc     = 0;

  always @(posedge aclk) cyc <= cyc + 1;
  always @(negedge aclk) if (s_err | b_err) err_cnt <= err_cnt + 1;

  logic [31:0] wbuf [200];
  logic [31:0] xbuf [20];
  logic [31:0] ebuf [10];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input bit is_w, input logic [31:0] d, input logic last, input string tag);
    int n = 0;
    if (is_w) begin w_tdata = d; w_tlast = last; w_tvalid = 1'b1; end
    else      begin x_tdata = d; x_tlast = last; x_tvalid = 1'b1; end
    while (!(is_w ? w_tready : x_tready) && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (n == 100) check({tag, " tready timeout"}, is_w ? w_tready : x_tready, 1'b1);
    @(negedge aclk);
    w_tvalid = 1'b0;
    x_tvalid = 1'b0;
  endtask

  task automatic load_weights(input int n, input bit with_last);
    for (int k = 0; k < n; k++)
      send(1'b1, wbuf[k], with_last && (k == n - 1), "weight");
  endtask

  task automatic send_vec(input int n, input int last_idx);
    for (int i = 0; i < n; i++)
      send(1'b0, xbuf[i], i == last_idx, "input");
  endtask

  task automatic recv(input logic [31:0] ed, input logic el, input int stall,
                      input string tag, output int t_valid);
    int n = 0;
    logic [31:0] d0;
    logic l0;
    bit ok = 1'b1;
    o_tready = (stall == 0);
    while (!o_tvalid && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    t_valid = cyc;
    check({tag, " tvalid"}, o_tvalid, 1'b1);
    if (stall > 0) begin
      d0 = o_tdata;
      l0 = o_tlast;
      repeat (stall) begin
        @(negedge aclk);
        if (o_tvalid !== 1'b1 || o_tdata !== d0 || o_tlast !== l0 || busy !== 1'b1) ok = 1'b0;
      end
      check({tag, " stable under stall"}, ok, 1'b1);
      o_tready = 1'b1;
    end
    check({tag, " tdata"}, o_tdata, ed);
    check({tag, " tlast"}, o_tlast, el);
    @(negedge aclk);
    o_tready = 1'b1;
  endtask

  task automatic run_vec(input int nin, input int nout, input int stall_idx, input string tag);
    int t0, tv;
    send_vec(nin, nin - 1);
    t0 = cyc;
    for (int j = 0; j < nout; j++) begin
      recv(ebuf[j], j == nout - 1, (j == stall_idx) ? 50 : 0, $sformatf("%s r%0d", tag, j), tv);
      if (j == 0) check({tag, " first latency"}, tv - t0, nin);
    end
    if (stall_idx < 0) check({tag, " total cycles"}, cyc - t0, nout * (nin + 1));
    check({tag, " busy after frame"}, busy, 1'b0);
  endtask

  task automatic set4(input int j, input logic [31:0] a, b, c, d);
    wbuf[j*4] = a; wbuf[j*4+1] = b; wbuf[j*4+2] = c; wbuf[j*4+3] = d;
  endtask

  task automatic set_x4(input logic [31:0] a, b, c, d);
    xbuf[0] = a; xbuf[1] = b; xbuf[2] = c; xbuf[3] = d;
  endtask

  task automatic set_e3(input logic [31:0] a, b, c);
    ebuf[0] = a; ebuf[1] = b; ebuf[2] = c;
  endtask

  task automatic basic_setup();
    set4(0, 32'h0001_0000, 32'h0, 32'h0, 32'h0);
    set4(1, 32'h0, 32'h0002_0000, 32'h0, 32'h0);
    set4(2, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000);
    set_x4(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    set_e3(32'h0001_0000, 32'h0004_0000, 32'h0005_0000);
  endtask

  function automatic logic [31:0] golden(input int j, input int nin);
    longint s = 0;
    for (int i = 0; i < nin; i++)
      s += longint'($signed(wbuf[j*nin+i])) * longint'($signed(xbuf[i]));
    s = s >>> 16;
    return s[31:0];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  e0;
    bit  ok;
    big = 1'b0; rst = 1'b1;
    w_tdata = '0; w_tlast = 1'b0; w_tvalid = 1'b0;
    x_tdata = '0; x_tlast = 1'b0; x_tvalid = 1'b1; o_tready = 1'b1;

    // Reset with input valid held, then no weights loaded
    repeat (20) @(negedge aclk);
    check("rst small outputs",
          {s_o_tdata, s_o_tlast, s_o_tvalid, s_w_tready, s_x_tready, s_err, s_busy}, '0);
    check("rst big outputs",
          {b_o_tdata, b_o_tlast, b_o_tvalid, b_w_tready, b_x_tready, b_err, b_busy}, '0);
    rst = 1'b0;
    ok  = 1'b1;
    repeat (8) begin
      @(negedge aclk);
      if (x_tready !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("no weights input stalled", ok, 1'b1);
    x_tvalid = 1'b0;
    @(negedge aclk);

    // Basic 4x3 frame, then the same frame with a 50-cycle stall on result 1
    basic_setup();
    e0 = err_cnt;
    load_weights(12, 1'b1);
    run_vec(4, 3, -1, "basic");
    run_vec(4, 3, 1, "backpressure");
    check("clean frames no err_len", err_cnt - e0, 0);

    // Sign handling and floor rounding
    set4(0, 32'hFFFE_8000, 32'h0, 32'h0, 32'h0);
    set4(1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    set4(2, 32'h0000_8000, 32'h0000_8000, 32'h0, 32'h0);
    set_x4(32'h0002_0000, 32'h0000_8000, 32'h0, 32'h0);
    set_e3(32'hFFFD_0000, 32'hFFFF_FFFF, 32'h0001_4000);
    load_weights(12, 1'b1);
    run_vec(4, 3, -1, "sign");

    // Positive and negative saturation
    for (int k = 0; k < 12; k++) wbuf[k] = 32'h7FFF_0000;
    set_x4(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000);
    set_e3(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    load_weights(12, 1'b1);
    run_vec(4, 3, -1, "sat pos");
    for (int k = 0; k < 12; k++) wbuf[k] = 32'h8000_0000;
    set_e3(32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    load_weights(12, 1'b1);
    run_vec(4, 3, -1, "sat neg");

    // Early input TLAST on beat 2 of 4
    basic_setup();
    e0 = err_cnt;
    send_vec(2, 1);
    ok = 1'b1;
    repeat (20) begin
      @(negedge aclk);
      if (o_tvalid !== 1'b0) ok = 1'b0;
    end
    check("early x tlast no output", ok, 1'b1);
    check("early x tlast idle", busy, 1'b0);
    check("early x tlast err pulses", err_cnt - e0, 1);

    // Weight frame without TLAST still loads; the next vector must be correct
    e0 = err_cnt;
    load_weights(12, 1'b0);
    @(negedge aclk);
    check("missing w tlast err pulses", err_cnt - e0, 1);
    run_vec(4, 3, -1, "after frame errors");

    // Early weight TLAST invalidates the weights
    e0 = err_cnt;
    load_weights(5, 1'b1);
    @(negedge aclk);
    check("early w tlast err pulses", err_cnt - e0, 1);
    x_tdata = xbuf[0]; x_tlast = 1'b0; x_tvalid = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(negedge aclk);
      if (x_tready !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("early w tlast input stalled", ok, 1'b1);
    x_tvalid = 1'b0;
    @(negedge aclk);

    // Default 20x10 instance, two different weight sets
    big = 1'b1;
    @(negedge aclk);
    for (int j = 0; j < 10; j++)
      for (int i = 0; i < 20; i++)
        wbuf[j*20+i] = 32'(((i + j) % 5 - 2) * 65536);
    for (int i = 0; i < 20; i++) xbuf[i] = 32'(i * 32768);
    for (int j = 0; j < 10; j++) ebuf[j] = golden(j, 20);
    e0 = err_cnt;
    load_weights(200, 1'b1);
    run_vec(20, 10, -1, "dflt A");
    for (int j = 0; j < 10; j++)
      for (int i = 0; i < 20; i++)
        wbuf[j*20+i] = 32'((j - i) * 16384);
    for (int j = 0; j < 10; j++) ebuf[j] = golden(j, 20);
    load_weights(200, 1'b1);
    run_vec(20, 10, -1, "dflt B");
    check("dflt no err_len", err_cnt - e0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
